// File: rtl/seq_mult_unit.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, sign handled by
// magnitude multiply plus final negate, optional accumulate of each product.
module seq_mult_unit #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2*WIDTH+4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               op_signed,
  input  logic               op_acc,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [ACC_W-1:0]   acc,
  output logic               busy
);
  localparam int PW = 2*WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;

  logic [PW-1:0]    mcand, sum, sum_nxt, res_nxt;
  logic [WIDTH-1:0] mplier, mag_a, mag_b;
  logic [CW-1:0]    cnt;
  logic             neg, sgn, acc_en, accept, last;
  logic [ACC_W-1:0] ext_s, ext_u, ext;

  assign accept = in_valid && (state == IDLE);
  assign last   = (state == BUSY) && (cnt == CW'(WIDTH-1));

  // -2^(W-1) negates to itself, which read unsigned is exactly its magnitude
  assign mag_a = (op_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b = (op_signed && op_b[WIDTH-1]) ? -op_b : op_b;

  assign sum_nxt = sum + (mplier[0] ? mcand : '0);
  assign res_nxt = neg ? -sum_nxt : sum_nxt;
  assign ext_s   = ACC_W'($signed(res_nxt));
  assign ext_u   = ACC_W'(res_nxt);
  assign ext     = sgn ? ext_s : ext_u;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == BUSY);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      sum    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      sgn    <= 1'b0;
      acc_en <= 1'b0;
      result <= '0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, mag_a};
      mplier <= mag_b;
      sum    <= '0;
      cnt    <= '0;
      neg    <= op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      sgn    <= op_signed;
      acc_en <= op_acc;
    end else if (state == BUSY) begin
      sum    <= sum_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= last ? '0 : cnt + CW'(1);
      if (last) result <= res_nxt;
    end
  end

  // clear takes priority over a product landing on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 acc <= '0;
    else if (acc_clr)        acc <= '0;
    else if (last && acc_en) acc <= acc + ext;
  end
endmodule

// File: tb/tb_seq_mult_unit.sv
// Randomised and directed checks of seq_mult_unit at WIDTH=8 and WIDTH=4
// against an integer-arithmetic reference.
module tb_seq_mult_unit;
  localparam int AW8 = 20;
  localparam int AW4 = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, op_signed, op_acc, acc_clr, out_valid, out_ready, busy;
  logic [7:0]  op_a, op_b;
  logic [15:0] result;
  logic [19:0] acc;

  logic        v4, r4, s4, a4, c4, ov4, or4, b4;
  logic [3:0]  a4_op, b4_op;
  logic [7:0]  res4;
  logic [11:0] acc4;

  seq_mult_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_signed(op_signed), .op_acc(op_acc),
    .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .acc(acc), .busy(busy));

  seq_mult_unit #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4),
    .op_a(a4_op), .op_b(b4_op), .op_signed(s4), .op_acc(a4),
    .acc_clr(c4), .out_valid(ov4), .out_ready(or4),
    .result(res4), .acc(acc4), .busy(b4));

  int     nvec = 0, nerr = 0;
  longint acc_m = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  function automatic longint sx(input longint v, input int w, input bit s);
    return (s && v >= (64'sd1 <<< (w-1))) ? v - (64'sd1 <<< w) : v;
  endfunction

  function automatic longint prod(input longint a, input longint b, input int w, input bit s);
    return sx(a, w, s) * sx(b, w, s);
  endfunction

  task automatic op8(input int a, input int b, input bit s, input bit ac, input bit clr);
    longint p;
    int lat;
    p = prod(a, b, 8, s);
    in_valid = 1; op_a = 8'(a); op_b = 8'(b); op_signed = s; op_acc = ac;
    step;
    in_valid = 0; op_a = 8'($urandom); op_b = 8'($urandom); op_signed = 1'($urandom);
    chk("busy", busy, 1);
    chk("in_ready_busy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (clr && lat == 7) acc_clr = 1;
      step;
      acc_clr = 0;
      lat++;
    end
    if (clr) acc_m = 0;
    else if (ac) acc_m = (acc_m + p) & ((64'sd1 <<< AW8) - 1);
    chk("latency8", lat, 8);
    chk("result8", result, p & 16'hFFFF);
    chk("acc8", acc, acc_m);
    out_ready = 1;
    step;
    out_ready = 0;
    chk("in_ready_after", in_ready, 1);
    chk("out_valid_after", out_valid, 0);
  endtask

  task automatic op4(input int a, input int b, input bit s);
    longint p;
    int lat;
    p = prod(a, b, 4, s);
    v4 = 1; a4_op = 4'(a); b4_op = 4'(b); s4 = s;
    step;
    v4 = 0; a4_op = 4'($urandom); b4_op = 4'($urandom);
    lat = 0;
    while (!ov4 && lat < 20) begin step; lat++; end
    chk("latency4", lat, 4);
    chk("result4", res4, p & 8'hFF);
    or4 = 1;
    step;
    or4 = 0;
    chk("in_ready4", r4, 1);
  endtask

  initial begin
    longint held;
    rst = 1;
    in_valid = 0; op_a = 0; op_b = 0; op_signed = 0; op_acc = 0; acc_clr = 0; out_ready = 0;
    v4 = 0; a4_op = 0; b4_op = 0; s4 = 0; a4 = 0; c4 = 0; or4 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_acc", acc, 0);
    rst = 0;
    step;

    // unsigned max and signed corners
    op8(255, 255, 0, 0, 0);  chk("u255", result, 16'hFE01);
    op8(8'h80, 8'h80, 1, 0, 0); chk("m128sq", result, 16'h4000);
    op8(8'hFD, 5, 1, 0, 0);  chk("m3x5", result, 16'hFFF1);
    op8(127, 8'h80, 1, 0, 0); chk("127xm128", result, 16'hC080);
    op8(0, 8'hFF, 1, 0, 0);  chk("0xm1", result, 0);

    // backpressure: DONE held while a different request is offered
    in_valid = 1; op_a = 12; op_b = 11; op_signed = 0; op_acc = 0;
    step;
    in_valid = 0;
    repeat (8) step;
    chk("bp_valid", out_valid, 1);
    held = 132;
    in_valid = 1; op_a = 3; op_b = 3;
    repeat (5) begin
      step;
      chk("bp_result", result, held);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    step;
    out_ready = 0;
    chk("bp_release", in_ready, 1);
    chk("bp_busy", busy, 0);

    // accumulate
    acc_clr = 1; step; acc_clr = 0; acc_m = 0;
    chk("acc_cleared", acc, 0);
    repeat (3) op8(10, 10, 0, 1, 0);
    chk("acc300", acc, 300);
    op8(10, 10, 0, 1, 1);
    chk("acc_clr_wins", acc, 0);
    op8(8'hFE, 3, 1, 1, 0);
    chk("acc_m6", acc, 20'hFFFFA);

    // reset mid-operation
    in_valid = 1; op_a = 200; op_b = 77; op_signed = 0; op_acc = 1;
    step;
    in_valid = 0;
    repeat (3) step;
    rst = 1;
    #1;
    chk("mr_in_ready", in_ready, 1);
    chk("mr_busy", busy, 0);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_result", result, 0);
    chk("mr_acc", acc, 0);
    acc_m = 0;
    @(posedge clk); #1;
    rst = 0;
    step;
    op8(7, 9, 0, 0, 0);
    chk("r7x9", result, 63);

    // randomised ops with random accumulate/clear
    repeat (150) op8($urandom_range(0, 255), $urandom_range(0, 255),
                     1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));

    // exhaustive WIDTH=4 sweep
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          op4(a, b, 1'(s));
    chk("acc4_idle", acc4, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/seq_mult_unit.md
# seq_mult_unit

Parametrised iterative shift-add multiplier with an optional multiply-accumulate mode. It generalises the team's fixed 4×4 combinational array multiplier to any operand width, and adds signed/unsigned selection and valid/ready handshakes on both input and output. It sits behind the top-level pin wrapper, or behind a PCPI-style co-processor front end, and trades latency (one partial product per cycle) for area.

## Interface
- WIDTH, 8, operand width in bits; legal values are ≥ 2.
- ACC_W, 2*WIDTH+4, accumulator width in bits; legal values are ≥ 2*WIDTH.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE; combinational from state.
- op_a  in  WIDTH  multiplicand.
- op_b  in  WIDTH  multiplier.
- op_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- op_acc  in  1  1 = add the product into acc when it completes.
- acc_clr  in  1  synchronous clear of acc; honoured in any state.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  2*WIDTH  product, two's complement when signed.
- acc  out  ACC_W  running accumulator.
- busy  out  1  high in BUSY.

## Operation
- State machine has three states: IDLE, BUSY and DONE. Reset forces IDLE.
- Reset values: in_ready=1, out_valid=0, busy=0, result=0, acc=0, bit counter=0.
- IDLE: an edge with in_valid&&in_ready captures the request and moves to BUSY. The capture stores:
  - |op_a| and |op_b| (magnitudes taken only when op_signed=1);
  - neg = op_signed & (op_a[MSB] ^ op_b[MSB]);
  - op_signed and op_acc.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), held as an unsigned WIDTH-bit value with no overflow.
- BUSY: each cycle examines one multiplier bit, LSB first. If the bit is 1, the shifted multiplicand is added into a 2*WIDTH-bit partial sum. The step counter runs 0..WIDTH-1.
- After the final step, the block moves to DONE and performs these actions:
  - result ← neg ? −sum : sum, taken modulo 2^(2W);
  - out_valid ← 1;
  - if op_acc was latched, acc ← acc + ext(result), wrapping modulo 2^ACC_W. ext is sign extension when signed, zero extension otherwise.
- DONE: result and out_valid are held stable until an edge with out_valid&&out_ready. That edge moves to IDLE and clears out_valid; result keeps its last value.
- in_valid outside IDLE is ignored, and operand changes during BUSY have no effect.
- acc_clr: acc ← 0 on the next edge. If it coincides with an accumulate update, the clear wins and that product is not added.
- Asserting rst mid-operation aborts immediately. All outputs return to their reset values and no partial result is ever presented.

## Timing
- Request accepted at edge E0; busy is high from E0 through edge E0+WIDTH.
- out_valid, result and acc are updated at edge E0+WIDTH. Latency is WIDTH cycles from accept to out_valid.
- If out_ready is already high, the handshake completes at E0+WIDTH+1 and in_ready is high after that edge.
- Minimum issue interval is WIDTH+2 cycles; there is no pipelining and only one outstanding operation.
- in_ready, busy and out_valid are glitch-free state decodes with no combinational path from in_valid or out_ready.

## Test plan
- Unsigned, WIDTH=8: 255×255 with op_signed=0 -> result=0xFE01. out_valid rises exactly 8 cycles after accept.
- Signed corners, WIDTH=8:
  - −128×−128 -> 0x4000;
  - −3×5 -> 0xFFF1;
  - 127×−128 -> 0xC080;
  - 0×−1 -> 0x0000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result, out_valid=1 and in_ready=0 stay stable. A new in_valid with different operands is ignored. Raising out_ready returns to IDLE after one edge.
- Accumulate: three ops of 10×10 with op_acc=1 -> acc=300 (0x12C). Then acc_clr together with a completing op_acc product -> acc=0. One signed −2×3 accumulate -> acc = ACC_W-bit −6.
- Reset mid-operation: assert rst 3 cycles into BUSY -> all outputs return to reset values immediately. A following 7×9 request completes normally with result=63.
- Parameter sweep: WIDTH=4 with all 256 unsigned and all 256 signed operand pairs, checked against a reference model. Latency is exactly 4 cycles for every pair.
